int_to_fp_converter: RTL and testbench
======================================

// Module: int_to_fp_converter
// PURPOSE
//  Pipelined integer-to-IEEE-754 single-precision converter; encoder side of the
//  float_point_num interface. Produces operands for floating_point_adder from
//  integer sources: same arg_vld in / result + res_state out handshake.
//  Fixed 3-cycle latency, one conversion accepted per cycle, no backpressure.
// PARAMETERS
//  INT_W   32  input integer width, legal 8..32
//  SIGNED  1   1: arg is two's complement; 0: arg is unsigned
// PORTS
//  clk        in   1                 system clock, all state on posedge
//  rst        in   1                 asynchronous reset, active-low (0 = reset)
//  arg        in   INT_W             integer to convert
//  arg_vld    in   1                 arg valid this cycle; sampled every cycle
//  result     out  float_point_num   {sign, exp[7:0], mant[22:0]}
//  res_vld    out  1                 result/res_state valid this cycle
//  res_state  out  2                 00 none, 01 exact, 10 inexact, 11 zero
// BEHAVIOUR
//  - Reset (rst=0, async assert, sync release): all stage valids, res_vld, result,
//    res_state clear to 0. In-flight conversions are discarded, not completed.
//  - Latency: arg sampled at edge N with arg_vld=1 -> res_vld=1 after edge N+3.
//    Back-to-back arg_vld gives back-to-back res_vld, order preserved.
//  - res_vld=0 cycles: result holds last value, res_state=00.
//  - S1: register sign (arg[INT_W-1] if SIGNED, else 0) and magnitude = |arg|
//    in INT_W bits, unsigned. -2^(INT_W-1) magnitude = 2^(INT_W-1), no overflow.
//  - S2: leading-zero count of magnitude (lzc sub-module); zero flag if mag==0.
//  - S3: left-normalise so MSB is the implicit 1; exp = 127 + (INT_W-1-lzc).
//    Keep 23 mantissa bits; guard = next bit, sticky = OR of remaining bits.
//    Round to nearest, ties to even: round up if guard & (sticky | mant[0]).
//    Mantissa carry-out on round-up: mant=0, exp+1 (no exp overflow for INT_W<=32).
//  - res_state: 11 if input zero (result = +0: sign 0, exp 0, mant 0);
//    10 if guard|sticky nonzero; else 01. Never produces NaN, Inf or subnormals.
//  - arg_vld=0 stages are bubbles: datapath regs may update, valids stay 0.
//  - Input X on arg while arg_vld=0 must not propagate to res_vld or res_state.
// STRUCTURE
//  - float_point_num typedef and res_state encodings (RES_NONE, RES_EXACT,
//    RES_INEXACT, RES_ZERO) and FP_BIAS=127 live in shared package fpu_pkg,
//    used by this block and floating_point_adder.
//  - One sub-module: fpu_lzc #(.W(INT_W)), combinational leading-zero counter,
//    output width $clog2(W)+1; reusable by the adder's normaliser.
//  - Top: three stage registers, each with valid bit + payload.
// TESTING
//  1 arg=0, vld 1 cycle -> 3 cycles later res_vld=1, result=0x00000000, state=11
//  2 arg=1 -> 0x3F800000 state 01; arg=-5 -> 0xC0A00000 state 01
//  3 arg=16777217 -> 0x4B800000 state 10 (tie to even, down);
//    arg=16777219 -> 0x4B800002 state 10 (tie to even, up)
//  4 arg=0x7FFFFFFF -> 0x4F000000 state 10 (round carry bumps exp);
//    arg=0x80000000 (SIGNED) -> 0xCF000000 state 01
//  5 Stream 1,2,3,4 on consecutive cycles -> res_vld high 4 cycles, results
//    0x3F800000,0x40000000,0x40400000,0x40800000 in order, no gaps
//  6 Assert rst=0 mid-stream with 2 in flight -> res_vld/res_state drop to 0
//    immediately and neither in-flight result ever emerges after release

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg
//   Shared floating-point definitions for the integer-to-float converter and
//   the floating-point adder.
//   float_point_num : packed IEEE-754 single-precision word {sign, exp, mant}
//   res_state_e     : status code travelling alongside each result
//   FP_BIAS         : single-precision exponent bias
package fpu_pkg;

  localparam int FP_BIAS = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_EXACT   = 2'b01,
    RES_INEXACT = 2'b10,
    RES_ZERO    = 2'b11
  } res_state_e;

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc
//   Combinational leading-zero counter, also reused by the adder's normaliser.
//   Ports:
//     value  in   W            word to examine
//     count  out  $clog2(W)+1  number of zeros above the highest set bit;
//                              equals W when value is all zeros
module fpu_lzc #(
  parameter int W = 32,
  localparam int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  // Scan upwards from bit 0 so the highest set bit is the last one to
  // overwrite the count; an all-zero word keeps the default of W.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) begin
        count = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter
//   Pipelined integer to IEEE-754 single-precision converter. Accepts one
//   conversion per cycle with no backpressure; a result appears three cycles
//   after the edge that captured its argument.
//   Ports:
//     clk        in   1                system clock
//     rst        in   1                asynchronous reset, active low
//     arg        in   INT_W            integer to convert
//     arg_vld    in   1                arg is valid this cycle
//     result     out  float_point_num  converted value, held while res_vld=0
//     res_vld    out  1                result/res_state valid this cycle
//     res_state  out  2                none / exact / inexact / zero
//   Pipeline:
//     S1  sign + magnitude
//     S2  leading-zero count and zero flag
//     S3  left-normalise, split mantissa / guard / sticky
//     out round to nearest even and format the result
module int_to_fp_converter
  import fpu_pkg::*;
#(
  parameter int INT_W  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] arg,
  input  logic             arg_vld,
  output float_point_num   result,
  output logic             res_vld,
  output logic [1:0]       res_state
);

  localparam int LZW = $clog2(INT_W) + 1;
  localparam logic [7:0] EXP_TOP = 8'(FP_BIAS + INT_W - 1);

  logic             arg_neg;
  logic [INT_W-1:0] arg_abs;

  logic             s1_vld;
  logic             s1_sign;
  logic [INT_W-1:0] s1_mag;

  logic [LZW-1:0]   lzc_cnt;
  logic             s2_vld;
  logic             s2_sign;
  logic             s2_zero;
  logic [INT_W-1:0] s2_mag;
  logic [LZW-1:0]   s2_lzc;

  logic [INT_W-1:0] norm;
  logic [31:0]      norm32;
  logic             s3_vld;
  logic             s3_sign;
  logic             s3_zero;
  logic [7:0]       s3_exp;
  logic [22:0]      s3_mant;
  logic             s3_guard;
  logic             s3_sticky;

  logic             round_up;
  logic [23:0]      mant_sum;

  // Magnitude of the most negative input wraps back to 2^(INT_W-1), which is
  // the correct unsigned magnitude, so no special case is needed.
  assign arg_neg = SIGNED && arg[INT_W-1];
  assign arg_abs = arg_neg ? ((~arg) + INT_W'(1)) : arg;

  // Stage valids are the only pipeline state that needs reset; clearing them
  // discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      s1_vld <= arg_vld;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  // S1 payload: updates freely, bubbles carry whatever arg held.
  always_ff @(posedge clk) begin
    s1_sign <= arg_neg;
    s1_mag  <= arg_abs;
  end

  fpu_lzc #(.W(INT_W)) u_lzc (
    .value (s1_mag),
    .count (lzc_cnt)
  );

  // S2 payload: leading-zero count and zero detect of the magnitude.
  always_ff @(posedge clk) begin
    s2_sign <= s1_sign;
    s2_mag  <= s1_mag;
    s2_lzc  <= lzc_cnt;
    s2_zero <= (s1_mag == '0);
  end

  // Shift the leading one to the top, then left-align into 32 bits so the
  // mantissa, guard and sticky fields sit at fixed positions for any INT_W.
  assign norm   = s2_mag << s2_lzc;
  assign norm32 = 32'(norm) << (32 - INT_W);

  // S3 payload: bit 31 of norm32 is the implicit one and is dropped.
  always_ff @(posedge clk) begin
    s3_sign   <= s2_sign;
    s3_zero   <= s2_zero;
    s3_exp    <= EXP_TOP - 8'(s2_lzc);
    s3_mant   <= norm32[30:8];
    s3_guard  <= norm32[7];
    s3_sticky <= |norm32[6:0];
  end

  // Round to nearest, ties to even. A carry out of the mantissa leaves the
  // low 23 bits at zero and bumps the exponent by one.
  assign round_up = s3_guard & (s3_sticky | s3_mant[0]);
  assign mant_sum = {1'b0, s3_mant} + 24'(round_up);

  // Output register: result only changes on a valid conversion so it holds
  // through idle cycles, while res_state returns to none.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld   <= 1'b0;
      res_state <= RES_NONE;
      result    <= '0;
    end else begin
      res_vld <= s3_vld;
      if (s3_vld) begin
        if (s3_zero) begin
          result    <= '0;
          res_state <= RES_ZERO;
        end else begin
          result.sign <= s3_sign;
          result.exp  <= s3_exp + 8'(mant_sum[23]);
          result.mant <= mant_sum[22:0];
          res_state   <= (s3_guard | s3_sticky) ? RES_INEXACT : RES_EXACT;
        end
      end else begin
        res_state <= RES_NONE;
      end
    end
  end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// tb_int_to_fp_converter
//   Directed-vector bench for int_to_fp_converter (INT_W=32, SIGNED=1).
//   Expected single-precision words are worked out by hand.
module tb_int_to_fp_converter;
  import fpu_pkg::*;

  logic           clk;
  logic           rst;
  logic [31:0]    arg;
  logic           arg_vld;
  float_point_num result;
  logic           res_vld;
  logic [1:0]     res_state;

  int checks;
  int errors;

  int_to_fp_converter #(.INT_W(32), .SIGNED(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg       (arg),
    .arg_vld   (arg_vld),
    .result    (result),
    .res_vld   (res_vld),
    .res_state (res_state)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one argument for a single cycle, then X on arg while idle, and
  // records what the outputs show before, at and after the expected slot.
  task automatic run_one(input logic [31:0] a,
                         output logic early_vld,
                         output logic got_vld, output logic [31:0] got_res,
                         output logic [1:0] got_state,
                         output logic idle_vld, output logic [31:0] idle_res,
                         output logic [1:0] idle_state);
    arg = a;
    arg_vld = 1'b1;
    @(posedge clk);
    #1;
    arg = 'x;
    arg_vld = 1'b0;
    early_vld = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (res_vld !== 1'b0) early_vld = 1'b1;
    end
    @(posedge clk);
    #1;
    got_vld = res_vld;
    got_res = result;
    got_state = res_state;
    @(posedge clk);
    #1;
    idle_vld = res_vld;
    idle_res = result;
    idle_state = res_state;
  endtask

  // Outputs clear under reset and stay clear with X on an idle arg.
  task automatic test_reset();
    rst = 1'b0;
    arg_vld = 1'b0;
    arg = 'x;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_vld: got %b expected 0", res_vld);
    end
    checks++;
    if (res_state !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected 00", res_state);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (res_vld !== 1'b0 || res_state !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_x_gating: got vld %b state %b expected 0 00", res_vld, res_state);
    end
  endtask

  // Zero input: exact three-cycle latency, +0 with zero status, then hold.
  task automatic test_zero();
    logic ev, gv, iv;
    logic [31:0] gr, ir;
    logic [1:0] gs, is;
    run_one(32'd0, ev, gv, gr, gs, iv, ir, is);
    checks++;
    if (ev !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_early: res_vld got %b expected 0 before latency", ev);
    end
    checks++;
    if (gv !== 1'b1 || gr !== 32'h0000_0000 || gs !== 2'b11) begin
      errors++;
      $display("[TB] FAIL zero_result: got vld %b %h state %b expected 1 00000000 11", gv, gr, gs);
    end
    checks++;
    if (iv !== 1'b0 || is !== 2'b00 || ir !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL zero_idle: got vld %b %h state %b expected 0 00000000 00", iv, ir, is);
    end
  endtask

  // Exactly representable values.
  task automatic test_exact();
    logic [31:0] args [4] = '{32'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd16777216};
    logic [31:0] exps [4] = '{32'h3F80_0000, 32'hC0A0_0000, 32'hBF80_0000, 32'h4B80_0000};
    logic ev, gv, iv;
    logic [31:0] gr, ir;
    logic [1:0] gs, is;
    for (int i = 0; i < 4; i++) begin
      run_one(args[i], ev, gv, gr, gs, iv, ir, is);
      checks++;
      if (ev !== 1'b0 || gv !== 1'b1 || gr !== exps[i] || gs !== 2'b01) begin
        errors++;
        $display("[TB] FAIL exact_%0d: got early %b vld %b %h state %b expected 0 1 %h 01",
                 i, ev, gv, gr, gs, exps[i]);
      end
      checks++;
      if (iv !== 1'b0 || is !== 2'b00 || ir !== exps[i]) begin
        errors++;
        $display("[TB] FAIL exact_hold_%0d: got vld %b %h state %b expected 0 %h 00",
                 i, iv, ir, is, exps[i]);
      end
    end
  endtask

  // Round to nearest even around 2^24 where one integer step is half an ulp.
  task automatic test_rounding();
    logic [31:0] args [3] = '{32'd16777217, 32'd16777218, 32'd16777219};
    logic [31:0] exps [3] = '{32'h4B80_0000, 32'h4B80_0001, 32'h4B80_0002};
    logic [1:0]  sts  [3] = '{2'b10, 2'b01, 2'b10};
    logic ev, gv, iv;
    logic [31:0] gr, ir;
    logic [1:0] gs, is;
    for (int i = 0; i < 3; i++) begin
      run_one(args[i], ev, gv, gr, gs, iv, ir, is);
      checks++;
      if (gv !== 1'b1 || gr !== exps[i] || gs !== sts[i]) begin
        errors++;
        $display("[TB] FAIL round_%0d: got vld %b %h state %b expected 1 %h %b",
                 i, gv, gr, gs, exps[i], sts[i]);
      end
    end
  endtask

  // Largest positive (rounding carries into exponent) and most negative input.
  task automatic test_boundary();
    logic ev, gv, iv;
    logic [31:0] gr, ir;
    logic [1:0] gs, is;
    run_one(32'h7FFF_FFFF, ev, gv, gr, gs, iv, ir, is);
    checks++;
    if (gv !== 1'b1 || gr !== 32'h4F00_0000 || gs !== 2'b10) begin
      errors++;
      $display("[TB] FAIL max_pos: got vld %b %h state %b expected 1 4f000000 10", gv, gr, gs);
    end
    run_one(32'h8000_0000, ev, gv, gr, gs, iv, ir, is);
    checks++;
    if (gv !== 1'b1 || gr !== 32'hCF00_0000 || gs !== 2'b01) begin
      errors++;
      $display("[TB] FAIL max_neg: got vld %b %h state %b expected 1 cf000000 01", gv, gr, gs);
    end
  endtask

  // Four consecutive arguments come out on four consecutive cycles in order.
  task automatic test_back_to_back();
    logic [31:0] args [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] exps [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    arg = args[0];
    arg_vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k + 1 < 4) begin
        arg = args[k + 1];
        arg_vld = 1'b1;
      end else begin
        arg = 'x;
        arg_vld = 1'b0;
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (res_vld !== 1'b1 || result !== exps[k - 3] || res_state !== 2'b01) begin
          errors++;
          $display("[TB] FAIL stream_%0d: got vld %b %h state %b expected 1 %h 01",
                   k - 3, res_vld, result, res_state, exps[k - 3]);
        end
      end else begin
        checks++;
        if (res_vld !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stream_gap_%0d: got vld %b expected 0", k, res_vld);
        end
      end
    end
  endtask

  // Reset asserted with one result showing and two still in flight.
  task automatic test_reset_midstream();
    arg = 32'd1;
    arg_vld = 1'b1;
    @(posedge clk);
    #1;
    arg = 32'd2;
    @(posedge clk);
    #1;
    arg = 32'd3;
    @(posedge clk);
    #1;
    arg = 'x;
    arg_vld = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (res_vld !== 1'b1 || result !== 32'h3F80_0000) begin
      errors++;
      $display("[TB] FAIL pre_reset: got vld %b %h expected 1 3f800000", res_vld, result);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (res_vld !== 1'b0 || res_state !== 2'b00 || result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got vld %b %h state %b expected 0 00000000 00",
               res_vld, result, res_state);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_vld !== 1'b0 || res_state !== 2'b00) begin
        errors++;
        $display("[TB] FAIL flushed_%0d: got vld %b state %b expected 0 00", k, res_vld, res_state);
      end
    end
  endtask

  // Test sequence and summary.
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    arg = '0;
    arg_vld = 1'b0;
    test_reset();
    test_zero();
    test_exact();
    test_rounding();
    test_boundary();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
